// File: rtl/lcd_param_pkg.sv
// Shared definitions for the LCD parameter editor: FSM states, key indices
// and the edit step table.
package lcd_param_pkg;

    localparam int unsigned NUM_KEYS = 9;
    localparam int unsigned NUM_CH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_COMMIT
    } state_e;

    // Keys 0..3 select a channel; the rest are editing commands.
    localparam logic [3:0] KEY_UP     = 4'd4;
    localparam logic [3:0] KEY_DOWN   = 4'd5;
    localparam logic [3:0] KEY_STEP   = 4'd6;
    localparam logic [3:0] KEY_OK     = 4'd7;
    localparam logic [3:0] KEY_CANCEL = 4'd8;

    // Step table indexed by step_sel.
    function automatic int unsigned step_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 1;
            2'd1:    return 10;
            2'd2:    return 100;
            default: return 1000;
        endcase
    endfunction

endpackage

// File: rtl/lcd_param_sat_step.sv
// Saturating increment/decrement of the working value by the selected step.
module lcd_param_sat_step
    import lcd_param_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned VMAX = 50000,
    parameter int unsigned VMIN = 0
) (
    input  logic [DW-1:0] value,
    input  logic [1:0]    step_sel,
    output logic [DW-1:0] inc_val_c,
    output logic [DW-1:0] dec_val_c
);

    localparam int unsigned XW = DW + 2;

    logic [XW-1:0] val_x;
    logic [XW-1:0] step_x;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] dif_x;
    logic [XW-1:0] hi_x;
    logic [XW-1:0] lo_x;

    // Limits are tested via the sign bit of a wider difference, so no wrap.
    always_comb begin
        val_x     = XW'(value);
        step_x    = XW'(step_of(step_sel));
        sum_x     = val_x + step_x;
        dif_x     = val_x - step_x;
        hi_x      = XW'(VMAX) - sum_x;
        lo_x      = dif_x - XW'(VMIN);
        inc_val_c = hi_x[XW-1] ? DW'(VMAX) : sum_x[DW-1:0];
        dec_val_c = lo_x[XW-1] ? DW'(VMIN) : dif_x[DW-1:0];
    end

endmodule

// File: rtl/lcd_param_ctrl.sv
// Key-driven editor for four stored parameters with a ready/valid write-out
// of the confirmed value and an idle timeout while editing.
module lcd_param_ctrl
    import lcd_param_pkg::*;
#(
    parameter int unsigned DW          = 16,
    parameter int unsigned VMAX        = 50000,
    parameter int unsigned VMIN        = 0,
    parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                cfg_ready,
    output logic                cfg_valid,
    output logic [1:0]          cfg_ch,
    output logic [DW-1:0]       cfg_value,
    output logic                edit_active,
    output logic [1:0]          edit_ch,
    output logic [DW-1:0]       edit_value,
    output logic [1:0]          step_sel,
    output logic                key_err
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [NUM_KEYS-1:0] key_low_c;
    logic                key_multi_c;
    logic                key_vld_c;
    logic [3:0]          key_idx_c;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [DW-1:0]       stored_q [NUM_CH];
    logic                store_en_c;
    logic                cfg_valid_d;
    logic [1:0]          cfg_ch_d;
    logic [DW-1:0]       cfg_value_d;
    logic [1:0]          edit_ch_d;
    logic [DW-1:0]       edit_value_d;
    logic [1:0]          step_sel_d;
    logic [DW-1:0]       inc_val_c;
    logic [DW-1:0]       dec_val_c;

    lcd_param_sat_step #(
        .DW   (DW),
        .VMAX (VMAX),
        .VMIN (VMIN)
    ) u_sat_step (
        .value     (edit_value),
        .step_sel  (step_sel),
        .inc_val_c (inc_val_c),
        .dec_val_c (dec_val_c)
    );

    // A key event is valid only when exactly one key line is low.
    always_comb begin
        key_low_c   = ~key_n;
        key_multi_c = |(key_low_c & (key_low_c - NUM_KEYS'(1)));
        key_vld_c   = (|key_low_c) && !key_multi_c;
        key_idx_c   = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (key_low_c[i]) key_idx_c = 4'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cfg_valid_d  = cfg_valid;
        cfg_ch_d     = cfg_ch;
        cfg_value_d  = cfg_value;
        edit_ch_d    = edit_ch;
        edit_value_d = edit_value;
        step_sel_d   = step_sel;
        tmo_d        = '0;
        store_en_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_vld_c && (key_idx_c < KEY_UP)) begin
                    state_d      = ST_EDIT;
                    edit_ch_d    = key_idx_c[1:0];
                    edit_value_d = stored_q[key_idx_c[1:0]];
                    step_sel_d   = 2'd0;
                end
            end
            ST_EDIT: begin
                if (key_vld_c) begin
                    case (key_idx_c)
                        KEY_UP:     edit_value_d = inc_val_c;
                        KEY_DOWN:   edit_value_d = dec_val_c;
                        KEY_STEP:   step_sel_d   = step_sel + 2'd1;
                        KEY_OK: begin
                            state_d     = ST_COMMIT;
                            cfg_valid_d = 1'b1;
                            cfg_ch_d    = edit_ch;
                            cfg_value_d = edit_value;
                        end
                        KEY_CANCEL: state_d = ST_IDLE;
                        // Channel switch drops the unsaved edit but keeps the step.
                        default: begin
                            edit_ch_d    = key_idx_c[1:0];
                            edit_value_d = stored_q[key_idx_c[1:0]];
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_COMMIT: begin
                if (cfg_valid && cfg_ready) begin
                    store_en_c  = 1'b1;
                    cfg_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            cfg_valid   <= 1'b0;
            cfg_ch      <= '0;
            cfg_value   <= '0;
            edit_active <= 1'b0;
            edit_ch     <= '0;
            edit_value  <= DW'(VMIN);
            step_sel    <= '0;
            key_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cfg_valid   <= cfg_valid_d;
            cfg_ch      <= cfg_ch_d;
            cfg_value   <= cfg_value_d;
            edit_active <= (state_d != ST_IDLE);
            edit_ch     <= edit_ch_d;
            edit_value  <= edit_value_d;
            step_sel    <= step_sel_d;
            key_err     <= key_multi_c;
        end
    end

    // Per-channel stored values, written only on a completed handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) stored_q[i] <= DW'(VMIN);
        end else if (store_en_c) begin
            stored_q[cfg_ch] <= cfg_value;
        end
    end

endmodule

// File: tb/tb_lcd_param_ctrl.sv
// Directed bench: key presses queue expected display snapshots and writes;
// a negedge monitor pops and compares them as the DUT responds.
module tb_lcd_param_ctrl;

    localparam int unsigned DW = 16;

    typedef struct packed {
        logic          act;
        logic [1:0]    ch;
        logic [DW-1:0] val;
        logic [1:0]    step;
        logic          err;
    } snap_t;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] val;
    } cfg_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8:0]    key_n;
    logic          cfg_ready;
    logic          cfg_valid;
    logic [1:0]    cfg_ch;
    logic [DW-1:0] cfg_value;
    logic          edit_active;
    logic [1:0]    edit_ch;
    logic [DW-1:0] edit_value;
    logic [1:0]    step_sel;
    logic          key_err;

    int    n_chk = 0;
    int    n_err = 0;
    snap_t snap_q[$];
    cfg_t  cfg_q[$];

    lcd_param_ctrl #(
        .DW          (DW),
        .VMAX        (50000),
        .VMIN        (0),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .cfg_ready   (cfg_ready),
        .cfg_valid   (cfg_valid),
        .cfg_ch      (cfg_ch),
        .cfg_value   (cfg_value),
        .edit_active (edit_active),
        .edit_ch     (edit_ch),
        .edit_value  (edit_value),
        .step_sel    (step_sel),
        .key_err     (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: no matching expectation queued", name);
    endtask

    function automatic logic [8:0] kv(input int k);
        logic [8:0] m;
        m    = 9'h1FF;
        m[k] = 1'b0;
        return m;
    endfunction

    // Called at posedge+1: queue the expected display, hold the key one cycle.
    task automatic press(input logic [8:0] kn, input int a, input int c, input int v,
                         input int s, input int e);
        snap_t x;
        x.act  = 1'(a);
        x.ch   = 2'(c);
        x.val  = DW'(v);
        x.step = 2'(s);
        x.err  = 1'(e);
        snap_q.push_back(x);
        key_n = kn;
        @(posedge clk); #1;
        key_n = 9'h1FF;
    endtask

    task automatic push_cfg(input int c, input int v);
        cfg_t x;
        x.ch  = 2'(c);
        x.val = DW'(v);
        cfg_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cfg_valid"},   32'(cfg_valid),   0);
        chk({tag, ".cfg_ch"},      32'(cfg_ch),      0);
        chk({tag, ".cfg_value"},   32'(cfg_value),   0);
        chk({tag, ".edit_active"}, 32'(edit_active), 0);
        chk({tag, ".edit_ch"},     32'(edit_ch),     0);
        chk({tag, ".edit_value"},  32'(edit_value),  0);
        chk({tag, ".step_sel"},    32'(step_sel),    0);
        chk({tag, ".key_err"},     32'(key_err),     0);
    endtask

    // Monitor: display snapshot one cycle after each key, write on handshake.
    logic          pend    = 1'b0;
    int            snap_id = 0;
    logic          prev_v  = 1'b0;
    logic          prev_hs = 1'b0;
    logic [1:0]    prev_ch = '0;
    logic [DW-1:0] prev_val = '0;
    snap_t         mon_s;
    cfg_t          mon_c;

    always @(negedge clk) begin
        if (pend) begin
            if (snap_q.size() == 0) begin
                fail($sformatf("snap%0d", snap_id));
            end else begin
                mon_s = snap_q.pop_front();
                chk($sformatf("snap%0d.edit_active", snap_id), 32'(edit_active), 32'(mon_s.act));
                chk($sformatf("snap%0d.edit_ch", snap_id),     32'(edit_ch),     32'(mon_s.ch));
                chk($sformatf("snap%0d.edit_value", snap_id),  32'(edit_value),  32'(mon_s.val));
                chk($sformatf("snap%0d.step_sel", snap_id),    32'(step_sel),    32'(mon_s.step));
                chk($sformatf("snap%0d.key_err", snap_id),     32'(key_err),     32'(mon_s.err));
            end
            snap_id++;
        end
        pend = rst_n && (key_n != 9'h1FF);
        if (rst_n && cfg_valid && cfg_ready) begin
            if (cfg_q.size() == 0) begin
                fail("cfg_write");
            end else begin
                mon_c = cfg_q.pop_front();
                chk("cfg_write.ch",    32'(cfg_ch),    32'(mon_c.ch));
                chk("cfg_write.value", 32'(cfg_value), 32'(mon_c.val));
            end
        end
        if (rst_n && prev_v && !prev_hs) begin
            chk("cfg_hold.valid", 32'(cfg_valid), 1);
            chk("cfg_hold.ch",    32'(cfg_ch),    32'(prev_ch));
            chk("cfg_hold.value", 32'(cfg_value), 32'(prev_val));
        end
        prev_v   = rst_n && cfg_valid;
        prev_hs  = cfg_valid && cfg_ready;
        prev_ch  = cfg_ch;
        prev_val = cfg_value;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        key_n     = 9'h1FF;
        cfg_ready = 1'b0;
        tick(3);
        chk_reset("reset");
        rst_n = 1'b1;
        tick(1);

        // Basic edit on channel 1, then cancel leaves storage untouched.
        press(kv(1), 1, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) press(kv(4), 1, 1, i, 0, 0);
        chk("edit_no_cfg_valid", 32'(cfg_valid), 0);
        press(kv(8), 0, 1, 3, 0, 0);
        press(kv(1), 1, 1, 0, 0, 0);
        press(kv(8), 0, 1, 0, 0, 0);

        // Channel 2: underflow clamp from 500 at step 1000, then climb to the ceiling.
        press(kv(2), 1, 2, 0, 0, 0);
        press(kv(6), 1, 2, 0, 1, 0);
        press(kv(6), 1, 2, 0, 2, 0);
        for (int i = 1; i <= 5; i++) press(kv(4), 1, 2, i * 100, 2, 0);
        press(kv(6), 1, 2, 500, 3, 0);
        press(kv(5), 1, 2, 0, 3, 0);
        press(kv(5), 1, 2, 0, 3, 0);
        for (int i = 1; i <= 49; i++) press(kv(4), 1, 2, i * 1000, 3, 0);
        press(kv(6), 1, 2, 49000, 0, 0);
        press(kv(6), 1, 2, 49000, 1, 0);
        press(kv(6), 1, 2, 49000, 2, 0);
        for (int i = 1; i <= 9; i++) press(kv(4), 1, 2, 49000 + i * 100, 2, 0);
        press(kv(6), 1, 2, 49900, 3, 0);
        press(kv(6), 1, 2, 49900, 0, 0);
        press(kv(6), 1, 2, 49900, 1, 0);
        for (int i = 1; i <= 9; i++) press(kv(4), 1, 2, 49900 + i * 10, 1, 0);
        press(kv(4), 1, 2, 50000, 1, 0);
        press(kv(4), 1, 2, 50000, 1, 0);
        press(kv(6), 1, 2, 50000, 2, 0);
        press(kv(6), 1, 2, 50000, 3, 0);
        press(kv(4), 1, 2, 50000, 3, 0);
        press(kv(5), 1, 2, 49000, 3, 0);

        // Confirm with downstream stalled for 10 cycles.
        push_cfg(2, 49000);
        press(kv(7), 1, 2, 49000, 3, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall%0d.cfg_valid", i), 32'(cfg_valid), 1);
            tick(1);
        end
        chk("stall10.cfg_valid", 32'(cfg_valid), 1);
        cfg_ready = 1'b1;
        tick(1);
        cfg_ready = 1'b0;
        chk("after_hs.cfg_valid",   32'(cfg_valid),   0);
        chk("after_hs.edit_active", 32'(edit_active), 0);
        press(kv(2), 1, 2, 49000, 0, 0);

        // Multi-key in EDIT, then channel switch keeps step and drops the edit.
        press(kv(4), 1, 2, 49001, 0, 0);
        press(9'h1EE, 1, 2, 49001, 0, 1);
        tick(1);
        chk("key_err_one_cycle", 32'(key_err), 0);
        press(kv(6), 1, 2, 49001, 1, 0);
        press(kv(1), 1, 1, 0, 1, 0);
        press(kv(2), 1, 2, 49000, 1, 0);

        // Ready already high when COMMIT is entered: single-cycle write.
        cfg_ready = 1'b1;
        press(kv(4), 1, 2, 49010, 1, 0);
        push_cfg(2, 49010);
        press(kv(7), 1, 2, 49010, 1, 0);
        tick(1);
        cfg_ready = 1'b0;
        chk("fast_hs.cfg_valid",   32'(cfg_valid),   0);
        chk("fast_hs.edit_active", 32'(edit_active), 0);
        press(kv(2), 1, 2, 49010, 0, 0);

        // Idle timeout: EDIT entered at edge E, IDLE after edge E+100.
        tick(98);
        chk("tmo98.edit_active", 32'(edit_active), 1);
        tick(1);
        chk("tmo99.edit_active", 32'(edit_active), 1);
        tick(1);
        chk("tmo100.edit_active", 32'(edit_active), 0);
        chk("tmo100.edit_ch",     32'(edit_ch),     2);
        chk("tmo100.edit_value",  32'(edit_value),  49010);
        press(kv(4), 0, 2, 49010, 0, 0);
        press(9'h1FC, 0, 2, 49010, 0, 1);

        // A key at cycle 98 restarts the count.
        press(kv(2), 1, 2, 49010, 0, 0);
        tick(97);
        press(kv(4), 1, 2, 49011, 0, 0);
        tick(3);
        chk("tmo_restart.edit_active", 32'(edit_active), 1);
        tick(96);
        chk("tmo_restart99.edit_active", 32'(edit_active), 1);
        tick(1);
        chk("tmo_restart100.edit_active", 32'(edit_active), 0);

        // Reset in the middle of a stalled COMMIT abandons the write.
        press(kv(2), 1, 2, 49010, 0, 0);
        press(kv(7), 1, 2, 49010, 0, 0);
        tick(2);
        chk("pre_reset.cfg_valid", 32'(cfg_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_commit_reset");
        tick(1);
        rst_n = 1'b1;
        tick(1);
        press(kv(2), 1, 2, 0, 0, 0);
        press(kv(3), 1, 3, 0, 0, 0);
        press(kv(8), 0, 3, 0, 0, 0);

        tick(2);
        chk("snap_q_drained", 32'(snap_q.size()), 0);
        chk("cfg_q_drained",  32'(cfg_q.size()),  0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_param_ctrl.md
LCD_PARAM_CTRL -- requirements
Module: lcd_param_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, width of all parameter values.
REQ-002 SHALL have parameter VMAX, default 50000, upper saturation limit of edited values.
REQ-003 SHALL have parameter VMIN, default 0, lower saturation limit of edited values.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 250_000_000, idle cycles in EDIT before auto-cancel (5 s at 50 MHz).
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port key_n  input  9  active-low one-cycle key pulses from the LCD key edge detector; idle 9'h1FF.
REQ-008 SHALL have port cfg_ready  input  1  downstream accepts the configuration write.
REQ-009 SHALL have port cfg_valid  output  1  configuration write pending.
REQ-010 SHALL have port cfg_ch  output  2  channel of the pending write.
REQ-011 SHALL have port cfg_value  output  DW  value of the pending write.
REQ-012 SHALL have port edit_active  output  1  high when state is not IDLE.
REQ-013 SHALL have port edit_ch  output  2  channel currently being edited or displayed.
REQ-014 SHALL have port edit_value  output  DW  working value for LCD display.
REQ-015 SHALL have port step_sel  output  2  step index: 0=1, 1=10, 2=100, 3=1000.
REQ-016 SHALL have port key_err  output  1  one-cycle pulse on a multi-key event.

Function
REQ-017 Key k SHALL be active when key_n[k]==0; exactly one low bit makes a valid key event.
REQ-018 More than one low bit SHALL be ignored, with key_err pulsed the next cycle in any state.
REQ-019 Key map SHALL be: 0-3 channel select, 4 up, 5 down, 6 step cycle, 7 confirm, 8 cancel.
REQ-020 States SHALL be IDLE, EDIT, COMMIT; all outputs registered; key event in cycle N reflected at N+1.
REQ-021 Four stored values SHALL be held, one per channel, each reset to VMIN.
REQ-022 IDLE: key 0-3 SHALL go to EDIT, loading edit_ch=k, edit_value=stored[k], step_sel=0; other keys ignored.
REQ-023 EDIT, key 0-3: SHALL switch channel, discarding the unsaved edit; reload stored[k]; keep step_sel.
REQ-024 EDIT, key 4: SHALL set edit_value=min(edit_value+step, VMAX), computed in DW+1 bits with no wrap.
REQ-025 EDIT, key 5: SHALL set edit_value=max(edit_value-step, VMIN), with no underflow wrap.
REQ-026 EDIT, key 6: SHALL cycle step_sel 0->1->2->3->0.
REQ-027 EDIT, key 7: SHALL go to COMMIT with cfg_ch=edit_ch and cfg_value=edit_value.
REQ-028 EDIT, key 8: SHALL return to IDLE with no write; stored values unchanged.
REQ-029 EDIT timeout counter SHALL clear on entry and on every valid key; at TIMEOUT_CYC-1 it SHALL force IDLE with no write.
REQ-030 COMMIT: cfg_valid SHALL be high, with cfg_ch/cfg_value stable until cfg_valid&&cfg_ready.
REQ-031 On handshake, stored[cfg_ch] SHALL be updated to cfg_value; cfg_valid SHALL drop next cycle; state SHALL go to IDLE.
REQ-032 cfg_ready high in the COMMIT entry cycle SHALL complete the handshake in one cycle.
REQ-033 COMMIT SHALL ignore all keys except for key_err reporting; no timeout applies.
REQ-034 In IDLE, edit_ch and edit_value SHALL hold their last values.
REQ-035 cfg_valid SHALL never be high outside COMMIT.

Reset
REQ-036 Asserted rst_n SHALL force IDLE, cfg_valid=0, cfg_ch=0, cfg_value=0, edit_active=0, edit_ch=0, edit_value=VMIN, step_sel=0, key_err=0, timeout counter=0, stored[0..3]=VMIN.
REQ-037 Reset during COMMIT SHALL abandon the write, leaving stored values at VMIN.

Structure
REQ-038 Shared package lcd_param_pkg SHALL hold the state enum, key index constants and the step table (1, 10, 100, 1000).
REQ-039 Saturating add/subtract SHALL be one combinational sub-module, lcd_param_sat_step.

Verification
REQ-040 Reset, then key 1 then key 4 x3 -> edit_active=1, edit_ch=1, edit_value=3; no cfg_valid.
REQ-041 Edit ch2 to 49990, step_sel=1, up -> 50000 (saturate); step 3, down from 500 -> 0.
REQ-042 Confirm with cfg_ready low 10 cycles, then high -> cfg_valid held 11 cycles, cfg_value stable; stored[ch] updated; IDLE; key 2 reloads the stored value.
REQ-043 key_n=9'h1EE in EDIT -> key_err pulse 1 cycle; edit_value unchanged.
REQ-044 TIMEOUT_CYC=100, enter EDIT, no keys -> IDLE at cycle 100; repeated key at cycle 98 -> no timeout.
REQ-045 rst_n low mid-COMMIT -> all outputs at reset values; stored values at VMIN.
